proc_controller: RTL and testbench
==================================

Name: proc_controller

Overview:
- Sequencing FSM of the processor datapath: fetches 16-bit instructions from a synchronous instruction ROM, holds PC and IR, decodes, and drives all datapath controls.
- Drives the register-file write-back 2-to-1 mux select (rf_s), the data memory, the register file and the ALU.
- Sits directly upstream of the write-back mux.

Parameters:
- PC_W, 7, program counter / instruction ROM address width.
- D_ADDR_W, 8, data memory address width; fixed by the instruction format, not overridable in practice.
- RF_ADDR_W, 4, register file address width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- instr_in  in  16  instruction ROM data; valid the cycle after pc_addr is presented.
- pc_addr  out  PC_W  instruction ROM address (PC register).
- d_addr  out  D_ADDR_W  data memory address.
- d_wr  out  1  data memory write enable.
- rf_s  out  1  write-back mux select: 0 = ALU result, 1 = data memory read data.
- rf_w_addr  out  RF_ADDR_W  register file write address.
- rf_w_en  out  1  register file write enable.
- rf_ra_addr  out  RF_ADDR_W  register file read port A address.
- rf_rb_addr  out  RF_ADDR_W  register file read port B address.
- alu_s  out  3  ALU op: 0 pass-A, 1 add, 2 sub.
- halted  out  1  high while in HALT.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Instruction format (IR[15:12] = opcode):
  - NOOP 0000.
  - STORE 0001 dddddddd rrrr: D[d] <= RF[r].
  - LOAD 0010 dddddddd rrrr: RF[r] <= D[d].
  - ADD 0011 aaaa bbbb cccc: RF[c] <= RF[a] + RF[b].
  - SUB 0100 aaaa bbbb cccc: RF[c] <= RF[a] - RF[b].
  - HALT 0101.
  - Opcodes 0110–1111 execute as NOOP.
- Reset (async, reset_n low):
  - State INIT, PC = 0, IR = 0.
  - d_wr, rf_w_en, rf_s, halted = 0; all addresses = 0; alu_s = 0.
  - Reset asserted mid-instruction aborts immediately; no partial write may occur after the reset edge.
- States: INIT, FETCH, DECODE, NOOP, STORE, LOAD_A, LOAD_B, ADD, SUB, HALT.
- INIT: 1 cycle, PC held at 0 -> FETCH.
- FETCH: pc_addr = PC (ROM registers it); at clock edge PC <= PC + 1, wrapping modulo 2^PC_W -> DECODE.
- DECODE: IR <= instr_in at clock edge; next state selected from instr_in[15:12].
- NOOP: no enables asserted -> FETCH.
- STORE:
  - d_addr = IR[11:4], rf_ra_addr = IR[3:0], alu_s = 0 (pass A), d_wr = 1 for exactly 1 cycle.
  - -> FETCH.
- LOAD_A:
  - d_addr = IR[11:4], rf_s = 1, no writes (synchronous memory read latency).
  - -> LOAD_B.
- LOAD_B:
  - d_addr held, rf_s = 1, rf_w_addr = IR[3:0], rf_w_en = 1.
  - -> FETCH.
- ADD / SUB:
  - rf_ra_addr = IR[11:8], rf_rb_addr = IR[7:4], rf_w_addr = IR[3:0], rf_s = 0, rf_w_en = 1.
  - alu_s = 1 (ADD) or 2 (SUB).
  - -> FETCH.
- HALT:
  - halted = 1, no enables asserted, PC frozen.
  - Remains in HALT until reset.
- Output timing: all control outputs are Moore (functions of state and IR only), so they are glitch-free relative to instr_in.
- Cycles per instruction: 3 for NOOP/STORE/ADD/SUB; 4 for LOAD.
- d_wr and rf_w_en are never high in the same cycle.

Decomposition:
- Shared package proc_pkg holds:
  - opcode localparams (OP_NOOP … OP_HALT),
  - the state enum typedef (4-bit),
  - ALU select constants,
  - RF_S_ALU = 0 / RF_S_MEM = 1.
- One natural sub-module: proc_decoder, a combinational state+IR -> control-output block. The state register, PC and IR remain in proc_controller.

Test Plan:
- Reset: hold reset_n low, toggle clk -> all outputs 0, state_o = INIT; release -> FETCH with pc_addr = 0 on the next edge, then DECODE.
- ADD: ROM[0] = 0x3125 -> in the ADD cycle: rf_ra_addr = 1, rf_rb_addr = 2, rf_w_addr = 5, alu_s = 1, rf_s = 0, rf_w_en = 1 for one cycle; PC = 1 on return to FETCH.
- LOAD then STORE:
  - ROM[0] = 0x2A03 -> LOAD_A with d_addr = 0xA0, rf_s = 1, rf_w_en = 0; then LOAD_B with rf_w_en = 1, rf_w_addr = 3.
  - ROM[1] = 0x1B07 -> d_addr = 0xB0, rf_ra_addr = 7, d_wr = 1 for one cycle.
- HALT: ROM[2] = 0x5000 -> halted = 1 and pc_addr stays at 3 for 20 cycles; illegal opcode 0xF123 behaves as NOOP (no enables asserted, 3 cycles).
- Reset mid-LOAD: assert reset_n low during LOAD_A -> outputs 0 asynchronously, rf_w_en never pulses, restart at PC = 0.
- PC wrap: run 128 NOOPs -> pc_addr wraps from 127 to 0 with no stall.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the processor sequencing controller: opcodes, FSM
// states, ALU / write-back select encodings and the control bundle.
package proc_pkg;

    localparam int IR_W         = 16;
    localparam int IR_D_ADDR_W  = 8;
    localparam int IR_RF_ADDR_W = 4;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOOP  = 4'h0;
    localparam opcode_t OP_STORE = 4'h1;
    localparam opcode_t OP_LOAD  = 4'h2;
    localparam opcode_t OP_ADD   = 4'h3;
    localparam opcode_t OP_SUB   = 4'h4;
    localparam opcode_t OP_HALT  = 4'h5;

    localparam logic [2:0] ALU_PASS_A = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;

    localparam logic RF_S_ALU = 1'b0;
    localparam logic RF_S_MEM = 1'b1;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_STORE  = 4'd4,
        ST_LOAD_A = 4'd5,
        ST_LOAD_B = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    typedef struct packed {
        logic [IR_D_ADDR_W-1:0]  d_addr;
        logic                    d_wr;
        logic                    rf_s;
        logic [IR_RF_ADDR_W-1:0] rf_w_addr;
        logic                    rf_w_en;
        logic [IR_RF_ADDR_W-1:0] rf_ra_addr;
        logic [IR_RF_ADDR_W-1:0] rf_rb_addr;
        logic [2:0]              alu_s;
        logic                    halted;
    } ctrl_t;

    // Opcodes 0110-1111 are not errors; they simply execute as NOOP.
    function automatic state_t op_to_state(input opcode_t op);
        case (op)
            OP_STORE: return ST_STORE;
            OP_LOAD:  return ST_LOAD_A;
            OP_ADD:   return ST_ADD;
            OP_SUB:   return ST_SUB;
            OP_HALT:  return ST_HALT;
            default:  return ST_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/proc_if.sv
// Controller <-> datapath/ROM bundle. No handshake: instr_in is valid the cycle
// after pc_addr is presented, and every control output is a registered Moore value.
interface proc_if #(
    parameter int PC_W      = 7,
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4
);
    logic [15:0]          instr_in;
    logic [PC_W-1:0]      pc_addr;
    logic [D_ADDR_W-1:0]  d_addr;
    logic                 d_wr;
    logic                 rf_s;
    logic [RF_ADDR_W-1:0] rf_w_addr;
    logic                 rf_w_en;
    logic [RF_ADDR_W-1:0] rf_ra_addr;
    logic [RF_ADDR_W-1:0] rf_rb_addr;
    logic [2:0]           alu_s;
    logic                 halted;
    logic [3:0]           state_o;

    modport master (
        input  instr_in,
        output pc_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s, halted, state_o
    );

    modport slave (
        output instr_in,
        input  pc_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s, halted, state_o
    );
endinterface

// File: rtl/proc_decoder.sv
// Combinational state + IR -> datapath control bundle. States without a listed
// action drive every enable and address low.
module proc_decoder
    import proc_pkg::*;
(
    input  state_t          state,
    input  logic [IR_W-1:0] ir,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_STORE: begin
                ctrl.d_addr     = ir[11:4];
                ctrl.rf_ra_addr = ir[3:0];
                ctrl.alu_s      = ALU_PASS_A;
                ctrl.d_wr       = 1'b1;
            end
            ST_LOAD_A: begin
                ctrl.d_addr = ir[11:4];
                ctrl.rf_s   = RF_S_MEM;
            end
            // Memory read data arrives one cycle after LOAD_A presented d_addr.
            ST_LOAD_B: begin
                ctrl.d_addr    = ir[11:4];
                ctrl.rf_s      = RF_S_MEM;
                ctrl.rf_w_addr = ir[3:0];
                ctrl.rf_w_en   = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                ctrl.rf_ra_addr = ir[11:8];
                ctrl.rf_rb_addr = ir[7:4];
                ctrl.rf_w_addr  = ir[3:0];
                ctrl.rf_s       = RF_S_ALU;
                ctrl.rf_w_en    = 1'b1;
                ctrl.alu_s      = (ir[15:12] == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/proc_controller.sv
// Processor sequencing FSM: holds PC and IR, walks FETCH/DECODE/execute and
// drives the data memory, register file, ALU and write-back mux select.
module proc_controller
    import proc_pkg::*;
#(
    parameter int PC_W      = 7,
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    proc_if.master   bus
);

    state_t          state, state_nx;
    logic [PC_W-1:0] pc, pc_nx;
    logic [IR_W-1:0] ir, ir_nx;
    ctrl_t           ctrl_nx, ctrl_q;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        case (state)
            ST_INIT:   state_nx = ST_FETCH;
            ST_FETCH: begin
                pc_nx    = pc + 1'b1;
                state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                ir_nx    = bus.instr_in;
                state_nx = op_to_state(bus.instr_in[15:12]);
            end
            ST_LOAD_A: state_nx = ST_LOAD_B;
            ST_NOOP, ST_STORE, ST_LOAD_B, ST_ADD, ST_SUB: state_nx = ST_FETCH;
            ST_HALT:   state_nx = ST_HALT;
            default:   state_nx = ST_INIT;
        endcase
    end

    // Decoding the next state/IR lets the controls come straight from flops
    // while still equalling decode(state, ir) in every cycle.
    proc_decoder u_decoder (
        .state (state_nx),
        .ir    (ir_nx),
        .ctrl  (ctrl_nx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_INIT;
            pc     <= '0;
            ir     <= '0;
            ctrl_q <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            ir     <= ir_nx;
            ctrl_q <= ctrl_nx;
        end
    end

    assign bus.pc_addr    = pc;
    assign bus.d_addr     = D_ADDR_W'(ctrl_q.d_addr);
    assign bus.d_wr       = ctrl_q.d_wr;
    assign bus.rf_s       = ctrl_q.rf_s;
    assign bus.rf_w_addr  = RF_ADDR_W'(ctrl_q.rf_w_addr);
    assign bus.rf_w_en    = ctrl_q.rf_w_en;
    assign bus.rf_ra_addr = RF_ADDR_W'(ctrl_q.rf_ra_addr);
    assign bus.rf_rb_addr = RF_ADDR_W'(ctrl_q.rf_rb_addr);
    assign bus.alu_s      = ctrl_q.alu_s;
    assign bus.halted     = ctrl_q.halted;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_proc_controller.sv
// Bench for proc_controller: an instruction-level model expands each ROM word
// into its expected per-cycle control trace; a monitor compares every cycle.
module tb_proc_controller;
    import proc_pkg::*;

    localparam int W = 38;

    // Field order: state, pc, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en, ra, rb, alu_s, halted
    localparam logic [W-1:0] M_ALL   = {W{1'b1}};
    localparam logic [W-1:0] M_BASE  = {4'hF, 7'h7F, 8'h00, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 3'h0, 1'b1};
    localparam logic [W-1:0] M_STORE = M_BASE | {4'h0, 7'h00, 8'hFF, 1'b0, 1'b0, 4'h0, 1'b0, 4'hF, 4'h0, 3'h7, 1'b0};
    localparam logic [W-1:0] M_LOADA = M_BASE | {4'h0, 7'h00, 8'hFF, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 3'h0, 1'b0};
    localparam logic [W-1:0] M_LOADB = M_LOADA | {4'h0, 7'h00, 8'h00, 1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 3'h0, 1'b0};
    localparam logic [W-1:0] M_ALU   = M_BASE | {4'h0, 7'h00, 8'h00, 1'b0, 1'b1, 4'hF, 1'b0, 4'hF, 4'hF, 3'h7, 1'b0};

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    proc_if bus ();

    proc_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- synchronous ROM model ----------------
    logic [15:0] rom [128];
    logic [6:0]  rom_addr;

    always @(posedge clk) begin
        rom_addr = bus.pc_addr;
        #1 bus.instr_in = rom[rom_addr];
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;
    int  cyc      = 0;

    function automatic logic [W-1:0] rec(input logic [3:0] st, input logic [6:0] pc,
                                         input logic [7:0] da, input logic dw, input logic rs,
                                         input logic [3:0] wa, input logic we, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [2:0] alu, input logic h);
        return {st, pc, da, dw, rs, wa, we, ra, rb, alu, h};
    endfunction

    function automatic logic [W-1:0] act_vec();
        return {bus.state_o, bus.pc_addr, bus.d_addr, bus.d_wr, bus.rf_s, bus.rf_w_addr,
                bus.rf_w_en, bus.rf_ra_addr, bus.rf_rb_addr, bus.alu_s, bus.halted};
    endfunction

    task automatic push(input logic [W-1:0] e, input logic [W-1:0] m);
        exp_q.push_back(e);
        mask_q.push_back(m);
    endtask

    task automatic chk(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp, input logic [W-1:0] mask);
        checks++;
        if (((got ^ exp) & mask) != '0) begin
            failures++;
            $display("FAIL %s got=%h exp=%h mask=%h", name, got, exp, mask);
        end
    endtask

    // Instruction-level reference: each instruction costs FETCH + DECODE plus its
    // execute cycles; after HALT the trace repeats HALT with the PC frozen.
    task automatic build_trace(input int n);
        logic [6:0]  pc;
        logic [6:0]  pcn;
        logic [15:0] ir;
        bit          stop;
        pc   = 7'd0;
        stop = 1'b0;
        exp_q.delete();
        mask_q.delete();
        while (exp_q.size() < n) begin
            if (stop) begin
                push(rec(ST_HALT, pc, 0, 0, 0, 0, 0, 0, 0, 0, 1), M_BASE);
            end else begin
                pcn = pc + 7'd1;
                ir  = rom[pc];
                push(rec(ST_FETCH, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE);
                push(rec(ST_DECODE, pcn, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE);
                case (ir[15:12])
                    4'h1: push(rec(ST_STORE, pcn, ir[11:4], 1, 0, 0, 0, ir[3:0], 0, 3'd0, 0), M_STORE);
                    4'h2: begin
                        push(rec(ST_LOAD_A, pcn, ir[11:4], 0, 1, 0, 0, 0, 0, 0, 0), M_LOADA);
                        push(rec(ST_LOAD_B, pcn, ir[11:4], 0, 1, ir[3:0], 1, 0, 0, 0, 0), M_LOADB);
                    end
                    4'h3: push(rec(ST_ADD, pcn, 0, 0, 0, ir[3:0], 1, ir[11:8], ir[7:4], 3'd1, 0), M_ALU);
                    4'h4: push(rec(ST_SUB, pcn, 0, 0, 0, ir[3:0], 1, ir[11:8], ir[7:4], 3'd2, 0), M_ALU);
                    4'h5: stop = 1'b1;
                    default: push(rec(ST_NOOP, pcn, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE);
                endcase
                pc = pcn;
            end
        end
        while (exp_q.size() > n) begin
            void'(exp_q.pop_back());
            void'(mask_q.pop_back());
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] m;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL trace_underflow cyc=%0d got=%h exp=none", cyc, act_vec());
            end else begin
                e = exp_q.pop_front();
                m = mask_q.pop_front();
                checks++;
                if (((act_vec() ^ e) & m) != '0) begin
                    failures++;
                    $display("FAIL trace cyc=%0d got=%h exp=%h mask=%h", cyc, act_vec(), e, m);
                end
            end
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", act_vec(), rec(ST_INIT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        reset_n = 1'b1;
        #1;
        chk("init_after_release", act_vec(), rec(ST_INIT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        @(posedge clk);
    endtask

    task automatic run(input int n);
        build_trace(n);
        do_reset();
        mon_en = 1'b1;
        repeat (n) @(posedge clk);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL trace_leftover got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic mid_load_reset();
        bit found;
        clear_rom();
        rom[0] = 16'h2A03;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.state_o == ST_LOAD_A) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reach_load_a got=timeout exp=LOAD_A");
        end else begin
            #2 reset_n = 1'b0;
            #1 chk("abort_async_zero", act_vec(), rec(ST_INIT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("held_in_reset", act_vec(), rec(ST_INIT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
            end
        end
        run(20);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] op;
        clear_rom();
        bus.instr_in = 16'h0000;

        // ADD, illegal opcode as NOOP, then HALT with PC frozen.
        rom[0] = 16'h3125;
        rom[1] = 16'hF123;
        rom[2] = 16'h5000;
        run(30);

        // LOAD, STORE, HALT.
        clear_rom();
        rom[0] = 16'h2A03;
        rom[1] = 16'h1B07;
        rom[2] = 16'h5000;
        run(30);

        mid_load_reset();

        // PC wrap through 127 -> 0 on a program of NOOP-class opcodes.
        for (int i = 0; i < 128; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(6, 15));
            rom[i] = {op, 12'($urandom)};
        end
        run(128 * 3 + 12);

        // Random programs with HALT made rare so most of the trace executes.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 128; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'h5 && $urandom_range(0, 15) != 0) op = 4'h3;
                rom[i] = {op, 12'($urandom)};
            end
            run(250);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
